// File: rtl/riscv_irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, default source count, width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_irq_pkg;

    localparam int DEFAULT_NUM_SRC = 4;

    // One request in flight: waiting in IDLE, offered to the core, or handler running.
    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_REQUEST    = 2'd1,
        S_IN_SERVICE = 2'd2
    } irq_state_e;

    // Bits needed to index n items; never less than 1 so a 2-source build still has an id bit.
    function automatic int clog2(input int n);
        int bits;
        bits = 1;
        while ((1 << bits) < n) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage : riscv_irq_pkg

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request bit is set and the lowest set index.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of req_i.
// Ports:
//   req_i  in   NUM_SRC  request vector, bit 0 = highest priority
//   vld_o  out  1        at least one bit of req_i set
//   id_o   out  ID_W     lowest set index (0 when vld_o is low)
module irq_prio_enc
    import riscv_irq_pkg::*;
#(
    parameter  int NUM_SRC = DEFAULT_NUM_SRC,
    localparam int ID_W    = clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    output logic               vld_o,
    output logic [ID_W-1:0]    id_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        vld_o = 1'b0;
        id_o  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                vld_o = 1'b1;
                id_o  = ID_W'(i);
            end
        end
    end

endmodule : irq_prio_enc

// File: rtl/riscv_irq_ctrl.sv
// Interrupt controller: latches source rising edges, masks and prioritises them, drives the core's interrupt line.
// Latency: source edge to interupt high is 2 cycles; mret to next request is 2 cycles.
// Backpressure: one request in flight; further edges wait in pending until the core returns with irq_done.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   irq_src               peripheral request lines, rising edge = request
//   mask_we, mask_wdata   mask register write port (1 = source enabled)
//   mask_o, pending_o     current mask and pending registers
//   interupt, irq_id      registered request to the core and the id being requested/serviced
//   irq_ack, irq_done     trap-taken and mret pulses from the core
//   in_service            handler running
module riscv_irq_ctrl
    import riscv_irq_pkg::*;
#(
    parameter  int NUM_SRC = DEFAULT_NUM_SRC,
    localparam int ID_W    = clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    output logic [NUM_SRC-1:0] mask_o,
    output logic [NUM_SRC-1:0] pending_o,
    output logic               interupt,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               in_service
);

    irq_state_e         state_q;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] rise_vec;
    logic [NUM_SRC-1:0] clr_vec;
    logic [ID_W-1:0]    irq_id_q;
    logic               interupt_q;
    logic               in_service_q;
    logic               enc_vld;
    logic [ID_W-1:0]    enc_id;

    // Mask only gates arbitration; pending keeps every edge so a later unmask still sees it.
    irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .req_i (pending_q & mask_q),
        .vld_o (enc_vld),
        .id_o  (enc_id)
    );

    always_comb begin
        rise_vec = irq_src & ~src_q;
        clr_vec  = '0;
        if ((state_q == S_REQUEST) && irq_ack) begin
            clr_vec = NUM_SRC'(1) << irq_id_q;
        end
        // A fresh edge on the acknowledged source survives the clear.
        pending_d = rise_vec | (pending_q & ~clr_vec);
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            // Load current levels so a source already high as reset drops is not seen as an edge.
            src_q        <= irq_src;
            pending_q    <= '0;
            mask_q       <= '0;
            irq_id_q     <= '0;
            interupt_q   <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            src_q     <= irq_src;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            case (state_q)
                S_IDLE: begin
                    if (enc_vld) begin
                        state_q    <= S_REQUEST;
                        irq_id_q   <= enc_id;
                        interupt_q <= 1'b1;
                    end
                end
                S_REQUEST: begin
                    // irq_id stays frozen here: a higher-priority arrival waits its turn.
                    if (irq_ack) begin
                        state_q      <= S_IN_SERVICE;
                        interupt_q   <= 1'b0;
                        in_service_q <= 1'b1;
                    end else if (!mask_q[irq_id_q]) begin
                        // Source masked while offered: withdraw, leave it pending.
                        state_q    <= S_IDLE;
                        interupt_q <= 1'b0;
                    end
                end
                S_IN_SERVICE: begin
                    if (irq_done) begin
                        state_q      <= S_IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    interupt_q   <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign mask_o     = mask_q;
    assign pending_o  = pending_q;
    assign interupt   = interupt_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;

endmodule : riscv_irq_ctrl

// File: tb/tb_riscv_irq_ctrl.sv
// Directed bench for riscv_irq_ctrl: reset, edge latching, priority, masking, stray handshakes, reset mid-service.
// Latency: n/a.
// Backpressure: n/a.
module tb_riscv_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_src;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic [3:0] mask_o;
    logic [3:0] pending_o;
    logic       interupt;
    logic [1:0] irq_id;
    logic       irq_ack;
    logic       irq_done;
    logic       in_service;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_irq_ctrl #(.NUM_SRC(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask_o     (mask_o),
        .pending_o  (pending_o),
        .interupt   (interupt),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs are changed right after this returns.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        irq_src    = 4'b0100;
        mask_we    = 1'b0;
        mask_wdata = 4'h0;
        irq_ack    = 1'b0;
        irq_done   = 1'b0;

        // 1: reset with src2 held high, then enable all; no spurious edge.
        step();
        step();
        chk("rst_mask",     32'(mask_o),     32'h0);
        chk("rst_pending",  32'(pending_o),  32'h0);
        chk("rst_int",      32'(interupt),   32'h0);
        chk("rst_insvc",    32'(in_service), 32'h0);
        chk("rst_id",       32'(irq_id),     32'h0);
        reset      = 1'b0;
        mask_we    = 1'b1;
        mask_wdata = 4'hF;
        step();
        mask_we = 1'b0;
        chk("t1_mask",      32'(mask_o),     32'hF);
        step();
        step();
        chk("t1_pending",   32'(pending_o),  32'h0);
        chk("t1_int",       32'(interupt),   32'h0);
        irq_src = 4'b0000;
        step();

        // 2: single source, full handshake, two-cycle latency.
        irq_src = 4'b0100;
        step();
        irq_src = 4'b0000;
        chk("t2_pend_set",  32'(pending_o),  32'h4);
        chk("t2_int_early", 32'(interupt),   32'h0);
        step();
        chk("t2_int",       32'(interupt),   32'h1);
        chk("t2_id",        32'(irq_id),     32'h2);
        chk("t2_insvc0",    32'(in_service), 32'h0);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t2_ack_int",   32'(interupt),   32'h0);
        chk("t2_ack_insvc", 32'(in_service), 32'h1);
        chk("t2_ack_pend",  32'(pending_o),  32'h0);
        irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        chk("t2_done",      32'(in_service), 32'h0);
        step();
        chk("t2_idle_int",  32'(interupt),   32'h0);

        // 3: simultaneous edges on src1 and src3; src1 wins, src3 follows two edges after done.
        irq_src = 4'b1010;
        step();
        irq_src = 4'b0000;
        step();
        chk("t3_int1",      32'(interupt),   32'h1);
        chk("t3_id1",       32'(irq_id),     32'h1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t3_pend",      32'(pending_o),  32'h8);
        irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        chk("t3_gap_int",   32'(interupt),   32'h0);
        step();
        chk("t3_int3",      32'(interupt),   32'h1);
        chk("t3_id3",       32'(irq_id),     32'h3);
        irq_ack = 1'b1;
        step();
        irq_ack  = 1'b0;
        irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        chk("t3_b2b_insvc", 32'(in_service), 32'h0);
        chk("t3_b2b_pend",  32'(pending_o),  32'h0);

        // 4: masked edge is still latched; unmask raises the request two edges after the write.
        mask_we    = 1'b1;
        mask_wdata = 4'h0;
        step();
        mask_we = 1'b0;
        irq_src = 4'b0001;
        step();
        irq_src = 4'b0000;
        step();
        chk("t4_pend",      32'(pending_o),  32'h1);
        chk("t4_int_mask",  32'(interupt),   32'h0);
        mask_we    = 1'b1;
        mask_wdata = 4'b0001;
        step();
        mask_we = 1'b0;
        chk("t4_int_w1",    32'(interupt),   32'h0);
        step();
        chk("t4_int_w2",    32'(interupt),   32'h1);
        chk("t4_id",        32'(irq_id),     32'h0);
        irq_ack = 1'b1;
        step();
        irq_ack  = 1'b0;
        irq_done = 1'b1;
        step();
        irq_done = 1'b0;

        // 5: withdraw by masking; stray done in REQUEST and stray ack in IDLE.
        mask_we    = 1'b1;
        mask_wdata = 4'hF;
        step();
        mask_we = 1'b0;
        irq_src = 4'b0100;
        step();
        irq_src = 4'b0000;
        step();
        chk("t5_int",       32'(interupt),   32'h1);
        chk("t5_id",        32'(irq_id),     32'h2);
        irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        chk("t5_stray_done_int",   32'(interupt),   32'h1);
        chk("t5_stray_done_insvc", 32'(in_service), 32'h0);
        mask_we    = 1'b1;
        mask_wdata = 4'b1011;
        step();
        mask_we = 1'b0;
        chk("t5_int_hold",  32'(interupt),   32'h1);
        step();
        chk("t5_int_drop",  32'(interupt),   32'h0);
        chk("t5_pend_kept", 32'(pending_o),  32'h4);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t5_stray_ack_insvc", 32'(in_service), 32'h0);
        chk("t5_stray_ack_pend",  32'(pending_o),  32'h4);
        chk("t5_stray_ack_int",   32'(interupt),   32'h0);

        // 6: reset while in service with other sources pending.
        mask_we    = 1'b1;
        mask_wdata = 4'hF;
        step();
        mask_we = 1'b0;
        step();
        chk("t6_int",       32'(interupt),   32'h1);
        irq_ack = 1'b1;
        irq_src = 4'b1010;
        step();
        irq_ack = 1'b0;
        irq_src = 4'b0000;
        chk("t6_insvc",     32'(in_service), 32'h1);
        chk("t6_pend",      32'(pending_o),  32'hA);
        reset = 1'b1;
        step();
        chk("t6_rst_insvc", 32'(in_service), 32'h0);
        chk("t6_rst_int",   32'(interupt),   32'h0);
        chk("t6_rst_pend",  32'(pending_o),  32'h0);
        chk("t6_rst_mask",  32'(mask_o),     32'h0);
        chk("t6_rst_id",    32'(irq_id),     32'h0);
        reset = 1'b0;
        step();
        step();
        chk("t6_post_int",  32'(interupt),   32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_riscv_irq_ctrl
